ahb_cfg_sync: RTL and testbench

//  Parametrised successor to the SSP config-register synchroniser. Brings an asynchronous request into
//  the HCLK domain through a SYNC_STAGES flop chain and captures the SSP config bundle plus NUM_CH

---
 rtl/ahb_cfg_sync.sv | 123 ++++++++++++
 tb/tb_ahb_cfg_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ahb_cfg_sync.sv
// ahb_cfg_sync: synchronises an async req into HCLK and captures the SSP config bundle plus data channels
module ahb_cfg_sync #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter bit HS_MODE     = 1'b0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         req,
    input  logic [ADDR_WIDTH-1:0]        DADR,
    input  logic [ADDR_WIDTH-1:0]        CADR,
    input  logic                         DLEN,
    input  logic                         DBIT,
    input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_I,
    input  logic [NUM_CH-1:0]            DATA_WE,
    input  logic                         clr_err,
    output logic                         ack,
    output logic                         REGs_ready,
    output logic [ADDR_WIDTH-1:0]        DADR_O,
    output logic [ADDR_WIDTH-1:0]        CADR_O,
    output logic                         DLEN_O,
    output logic                         DBIT_O,
    output logic [NUM_CH*DATA_WIDTH-1:0] DATA_O,
    output logic                         busy,
    output logic                         err_ovr
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t                         state_q, state_d;
    logic [SYNC_STAGES-1:0]         sync_q, sync_d;
    logic                           req_dly_q, req_dly_d;
    logic                           ack_q, ack_d;
    logic                           rdy_q, rdy_d;
    logic [ADDR_WIDTH-1:0]          dadr_q, dadr_d;
    logic [ADDR_WIDTH-1:0]          cadr_q, cadr_d;
    logic                           dlen_q, dlen_d;
    logic                           dbit_q, dbit_d;
    logic [NUM_CH*DATA_WIDTH-1:0]   data_q, data_d;
    logic                           err_q, err_d;
    logic                           req_s, evt, ovr;

    // Synchroniser shift, edge/toggle detection, handshake FSM and capture muxing
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], req};
        req_s     = sync_q[SYNC_STAGES-1];
        req_dly_d = req_s;
        evt       = HS_MODE ? (req_s ^ req_dly_q) : (req_s & ~req_dly_q);
        state_d   = state_q;
        ack_d     = ack_q;
        rdy_d     = 1'b0;
        dadr_d    = dadr_q;
        cadr_d    = cadr_q;
        dlen_d    = dlen_q;
        dbit_d    = dbit_q;
        data_d    = data_q;
        ovr       = 1'b0;
        case (state_q)
            IDLE: if (evt) begin
                dadr_d  = DADR;
                cadr_d  = CADR;
                dlen_d  = DLEN;
                dbit_d  = DBIT;
                for (int k = 0; k < NUM_CH; k++)
                    data_d[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WE[k] ? DATA_I[k*DATA_WIDTH +: DATA_WIDTH]
                                                                    : data_q[k*DATA_WIDTH +: DATA_WIDTH];
                rdy_d   = 1'b1;
                ack_d   = HS_MODE ? ~ack_q : 1'b1;
                state_d = ACK;
            end
            ACK: begin
                ovr     = evt;
                state_d = HS_MODE ? IDLE : WAIT_LOW;
            end
            WAIT_LOW: if (!req_s) begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = ovr | (err_q & ~clr_err);
    end

    // State and capture registers, cleared asynchronously
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            req_dly_q <= 1'b0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
            dadr_q    <= '0;
            cadr_q    <= '0;
            dlen_q    <= 1'b0;
            dbit_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            req_dly_q <= req_dly_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
            dadr_q    <= dadr_d;
            cadr_q    <= cadr_d;
            dlen_q    <= dlen_d;
            dbit_q    <= dbit_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign ack        = ack_q;
    assign REGs_ready = rdy_q;
    assign DADR_O     = dadr_q;
    assign CADR_O     = cadr_q;
    assign DLEN_O     = dlen_q;
    assign DBIT_O     = dbit_q;
    assign DATA_O     = data_q;
    assign busy       = (state_q != IDLE);
    assign err_ovr    = err_q;
endmodule

// File: tb/tb_ahb_cfg_sync.sv
// tb_ahb_cfg_sync: directed bench for four-phase, two-phase, deep-sync and channel-count variants
module tb_ahb_cfg_sync;
    logic HCLK = 1'b0, HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    logic        req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic [5:0]  dadr = '0, cadr = '0;
    logic        dlen = 1'b0, dbit = 1'b0;
    logic [31:0] di = '0;
    logic [1:0]  we = '0;
    logic [127:0] di2 = '0;
    logic [3:0]  we2 = '0;
    logic [31:0] di3 = '0;
    logic [0:0]  we3 = '0;

    logic ack0, rdy0, dlen0, dbit0, busy0, err0;
    logic ack1, rdy1, dlen1, dbit1, busy1, err1;
    logic ack2, rdy2, dlen2, dbit2, busy2, err2;
    logic ack3, rdy3, dlen3, dbit3, busy3, err3;
    logic [5:0] dadr0, cadr0, dadr1, cadr1, dadr2, cadr2, dadr3, cadr3;
    logic [31:0] data0, data1, data3;
    logic [127:0] data2;

    ahb_cfg_sync #(.HS_MODE(1'b0)) u0 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req0), .DADR(dadr), .CADR(cadr), .DLEN(dlen), .DBIT(dbit),
        .DATA_I(di), .DATA_WE(we), .clr_err(clr0), .ack(ack0), .REGs_ready(rdy0), .DADR_O(dadr0),
        .CADR_O(cadr0), .DLEN_O(dlen0), .DBIT_O(dbit0), .DATA_O(data0), .busy(busy0), .err_ovr(err0));

    ahb_cfg_sync #(.HS_MODE(1'b1)) u1 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req1), .DADR(dadr), .CADR(cadr), .DLEN(dlen), .DBIT(dbit),
        .DATA_I(di), .DATA_WE(we), .clr_err(clr1), .ack(ack1), .REGs_ready(rdy1), .DADR_O(dadr1),
        .CADR_O(cadr1), .DLEN_O(dlen1), .DBIT_O(dbit1), .DATA_O(data1), .busy(busy1), .err_ovr(err1));

    ahb_cfg_sync #(.DATA_WIDTH(32), .NUM_CH(4), .SYNC_STAGES(4)) u2 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req2), .DADR(dadr), .CADR(cadr), .DLEN(dlen), .DBIT(dbit),
        .DATA_I(di2), .DATA_WE(we2), .clr_err(1'b0), .ack(ack2), .REGs_ready(rdy2), .DADR_O(dadr2),
        .CADR_O(cadr2), .DLEN_O(dlen2), .DBIT_O(dbit2), .DATA_O(data2), .busy(busy2), .err_ovr(err2));

    ahb_cfg_sync #(.DATA_WIDTH(32), .NUM_CH(1), .SYNC_STAGES(4)) u3 (
        .HCLK(HCLK), .HRESET(HRESET), .req(req2), .DADR(dadr), .CADR(cadr), .DLEN(dlen), .DBIT(dbit),
        .DATA_I(di3), .DATA_WE(we3), .clr_err(1'b0), .ack(ack3), .REGs_ready(rdy3), .DADR_O(dadr3),
        .CADR_O(cadr3), .DLEN_O(dlen3), .DBIT_O(dbit3), .DATA_O(data3), .busy(busy3), .err_ovr(err3));

    int total = 0, passed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        req0 = 1'b1; req2 = 1'b1;
        dadr = 6'h3F; cadr = 6'h01; dlen = 1'b0; dbit = 1'b1;
        di = 32'hCAFE_0F0F; we = 2'b11;
        di2 = 128'h4444_4444_3333_3333_2222_2222_1111_1111; we2 = 4'hF;
        di3 = 32'hDEAD_BEEF; we3 = 1'b1;
        tick(2);
        chk("rst_ack", ack0, 0);
        chk("rst_rdy", rdy0, 0);
        chk("rst_dadr", dadr0, 0);
        chk("rst_data", data0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_ack2", ack2, 0);
        HRESET = 1'b0;
        tick(2);
        chk("rel_ack_early", ack0, 0);
        tick(1);
        chk("rel_ack", ack0, 1);
        chk("rel_rdy", rdy0, 1);
        chk("rel_busy", busy0, 1);
        chk("rel_dadr", dadr0, 6'h3F);
        chk("rel_cadr", cadr0, 6'h01);
        chk("rel_dbit", dbit0, 1);
        chk("rel_data", data0, 32'hCAFE_0F0F);
        tick(1);
        chk("rel_rdy_off", rdy0, 0);
        chk("rel_ack_hold", ack0, 1);
        chk("s4_ack_early", ack2, 0);
        tick(1);
        chk("s4_ack", ack2, 1);
        chk("s4_rdy", rdy2, 1);
        chk("s4_data_4ch", data2, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        chk("s4_data_1ch", data3, 32'hDEAD_BEEF);
        chk("s4_ack_1ch", ack3, 1);
        req0 = 1'b0; req2 = 1'b0;
        tick(2);
        chk("drop_ack_hold", ack0, 1);
        tick(1);
        chk("drop_ack", ack0, 0);
        chk("drop_busy", busy0, 0);
        tick(2);
        chk("s4_drop_ack", ack2, 0);
        chk("s4_drop_busy", busy2, 0);

        dadr = 6'h2A; cadr = 6'h15; dlen = 1'b1; dbit = 1'b0;
        di = {16'hBEEF, 16'h1234}; we = 2'b11;
        req0 = 1'b1;
        tick(2);
        chk("m0_ack_early", ack0, 0);
        tick(1);
        chk("m0_ack", ack0, 1);
        chk("m0_rdy", rdy0, 1);
        chk("m0_dadr", dadr0, 6'h2A);
        chk("m0_cadr", cadr0, 6'h15);
        chk("m0_dlen", dlen0, 1);
        chk("m0_dbit", dbit0, 0);
        chk("m0_data", data0, 32'hBEEF_1234);
        tick(1);
        chk("m0_rdy_off", rdy0, 0);
        req0 = 1'b0;
        tick(3);
        chk("m0_ack_low", ack0, 0);

        di = {16'hAAAA, 16'h5555}; we = 2'b01;
        req0 = 1'b1;
        tick(3);
        chk("mask_rdy", rdy0, 1);
        chk("mask_data", data0, 32'hBEEF_5555);
        req0 = 1'b0;
        di = 32'h0000_0000; we = 2'b11;
        tick(5);
        chk("mask_hold", data0, 32'hBEEF_5555);
        chk("mask_ack_low", ack0, 0);
        chk("m0_no_err", err0, 0);

        for (int i = 0; i < 3; i++) begin
            di = 32'h1000_0000 + i;
            we = 2'b11;
            req1 = ~req1;
            tick(3);
            chk("m1_ack", ack1, (i % 2 == 0) ? 1 : 0);
            chk("m1_rdy", rdy1, 1);
            chk("m1_data", data1, 32'h1000_0000 + i);
            tick(1);
            chk("m1_rdy_off", rdy1, 0);
            chk("m1_idle", busy1, 0);
            tick(4);
        end
        chk("m1_no_err", err1, 0);

        di = 32'h7777_8888;
        req1 = ~req1;
        tick(1);
        req1 = ~req1;
        tick(2);
        chk("ovr_first_ack", ack1, 0);
        chk("ovr_first_rdy", rdy1, 1);
        chk("ovr_first_data", data1, 32'h7777_8888);
        tick(1);
        chk("ovr_err", err1, 1);
        chk("ovr_rdy_off", rdy1, 0);
        tick(3);
        chk("ovr_dropped_ack", ack1, 0);
        chk("ovr_err_sticky", err1, 1);
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        chk("ovr_clr", err1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
